bu_outpipe_elastic: RTL and testbench
=====================================

Name: bu_outpipe_elastic

Overview:
- Parametrised successor of the radix-16 butterfly output register stage.
- Carries LANES butterfly results through a DEPTH-stage elastic pipeline with valid/ready flow control.
- Emits a bit-reversal/address tap (BRD_WIDTH-bit slice of each lane) one cycle after each accepted output beat, with its own valid strobe.
- Sits between the butterfly datapath and the reorder/memory-write stage, which may stall.

Parameters:
- LANES, 16, number of parallel butterfly lanes (>=1).
- P_WIDTH, 64, data width per lane.
- DEPTH, 1, number of data register stages (1..8).
- BRD_WIDTH, 20, width of the per-lane BR tap.
- BRD_LSB, 0, LSB position of the BR slice within each lane word. Legal only if BRD_LSB+BRD_WIDTH <= P_WIDTH; otherwise elaboration error.

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- flush  in  1  synchronous flush: clears all valids.
- data_i  in  LANES*P_WIDTH  input lanes; lane k = bits [k*P_WIDTH +: P_WIDTH].
- valid_i  in  1  input beat valid.
- ready_o  out  1  pipeline can accept a beat this cycle.
- data_o  out  LANES*P_WIDTH  output lanes, same packing as data_i.
- valid_o  out  1  output beat valid.
- ready_i  in  1  downstream accepts a beat.
- br_o  out  LANES*BRD_WIDTH  BR taps; lane k = data_o lane k bits [BRD_LSB +: BRD_WIDTH] of the last accepted beat.
- br_valid_o  out  1  one-cycle strobe: br_o was updated.
- occ_o  out  4  number of valid stages (0..DEPTH).

Behaviour:
- Reset (rst_n low, async): all stage data, data_o and br_o = 0; all stage valids, valid_o and br_valid_o = 0; occ_o = 0; ready_o = 0 while rst_n is low.
- Stage s (0 = input side, DEPTH-1 = output) holds data[s] and v[s]. data_o = data[DEPTH-1]; valid_o = v[DEPTH-1].
- Advance rule:
  - adv[DEPTH-1] = ~v[DEPTH-1] | ready_i.
  - adv[s] = ~v[s] | adv[s+1].
  - ready_o = adv[0] (combinational, bubble-collapsing).
- On a clock edge where adv[s] = 1:
  - Stage s loads from stage s-1, or from data_i/valid_i for s = 0.
  - The incoming valid bit is copied; data is loaded only when the incoming valid is 1, so data holds on bubbles.
- Where adv[s] = 0, stage s holds.
- Latency: with no stall, input accepted at edge N appears on data_o after edge N+DEPTH-1 (DEPTH=1 gives one-register behaviour).
- Throughput: one beat per cycle when ready_i = 1. No beat is dropped or duplicated under any ready_i pattern.
- Input handshake = valid_i & ready_o. Output handshake = valid_o & ready_i.
- BR stage: on each output handshake, br_o captures the slice of data_o and br_valid_o = 1 in the next cycle. Otherwise br_valid_o = 0 and br_o holds. Total BR latency is output handshake + 1.
- occ_o: registered popcount of v[], updated each edge.
- flush = 1 at an edge:
  - All v[] = 0 and br_valid_o = 0; data and br_o hold their values.
  - The beat on data_i that edge is discarded even if valid_i & ready_o.
  - A handshake on the output that same edge still counts as consumed downstream, but produces no br strobe.
  - flush has priority over everything except reset.
- Simultaneous output pop and input push on a full pipeline: allowed; occupancy unchanged.
- Reset asserted mid-stream: all in-flight beats are lost. The first edge after release starts from the empty state.
- valid_i is ignored when ready_o = 0. The upstream sender must hold data_i/valid_i stable until accepted.

Test Plan:
- Default params, DEPTH=2, ready_i=1; push lane k = 64'h1000_0000_000A_BC00+k for 4 consecutive beats -> valid_o rises 2 edges after first push, 4 beats in order; br_o lane k = 20'hABC00+k one cycle after each beat with br_valid_o pulse.
- DEPTH=2, ready_i=0, push 3 beats -> first 2 accepted, occ_o = 2, ready_o = 0 on 3rd; raise ready_i -> 3 beats delivered in order, no loss or duplication.
- Random valid_i/ready_i (50%) over 1000 beats with scoreboard -> output sequence equals input sequence; br_valid_o count equals output handshake count.
- flush asserted with occ_o = 2 and valid_i = 1 -> next cycle valid_o = 0, occ_o = 0, br_valid_o = 0, input beat not delivered.
- rst_n pulsed low mid-stream (async, between edges) -> data_o, br_o, valid_o, br_valid_o, occ_o immediately 0 and ready_o = 0; after release, new beat latency = DEPTH edges.
- BRD_LSB=8, BRD_WIDTH=12, LANES=4, P_WIDTH=32, lane value 32'h00ABC123 -> br_o lane = 12'hBC1.

Source files
------------

// File: rtl/bu_outpipe_elastic.sv
// Elastic DEPTH-stage output pipeline for LANES butterfly results, with a
// bubble-collapsing valid/ready chain and a registered bit-reversal address tap.
module bu_outpipe_elastic #(
  parameter int LANES     = 16,
  parameter int P_WIDTH   = 64,
  parameter int DEPTH     = 1,
  parameter int BRD_WIDTH = 20,
  parameter int BRD_LSB   = 0
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         flush,
  input  logic [LANES*P_WIDTH-1:0]     data_i,
  input  logic                         valid_i,
  output logic                         ready_o,
  output logic [LANES*P_WIDTH-1:0]     data_o,
  output logic                         valid_o,
  input  logic                         ready_i,
  output logic [LANES*BRD_WIDTH-1:0]   br_o,
  output logic                         br_valid_o,
  output logic [3:0]                   occ_o
);

  localparam int DW = LANES * P_WIDTH;
  localparam int BW = LANES * BRD_WIDTH;

  if ((BRD_LSB + BRD_WIDTH) > P_WIDTH) begin : g_err_brd
    $error("bu_outpipe_elastic: BR slice exceeds lane width");
  end
  if ((DEPTH < 1) || (DEPTH > 8)) begin : g_err_depth
    $error("bu_outpipe_elastic: DEPTH must be 1..8");
  end
  if (LANES < 1) begin : g_err_lanes
    $error("bu_outpipe_elastic: LANES must be >= 1");
  end

  function automatic logic [3:0] popcnt(input logic [DEPTH-1:0] v);
    logic [3:0] c;
    c = '0;
    for (int i = 0; i < DEPTH; i++) c = c + {3'b000, v[i]};
    return c;
  endfunction

  logic [DW-1:0]    r_data [DEPTH];
  logic [DEPTH-1:0] r_v;
  logic [3:0]       r_occ;
  logic [BW-1:0]    r_br;
  logic             r_br_vld;

  logic [DW-1:0]    w_src [DEPTH];
  logic [DEPTH-1:0] w_vin;
  logic [DEPTH-1:0] w_adv;
  logic [DEPTH-1:0] w_v_nxt;
  logic [BW-1:0]    w_br_slice;
  logic             w_out_hs;

  // A stage may advance unless it and every stage downstream are full and stalled.
  always_comb begin
    logic tail_full;
    tail_full = 1'b1;
    w_adv     = '0;
    for (int s = DEPTH - 1; s >= 0; s--) begin
      tail_full = tail_full & r_v[s];
      w_adv[s]  = ready_i | ~tail_full;
    end
  end

  always_comb begin
    w_v_nxt = r_v;
    for (int s = 0; s < DEPTH; s++) begin
      if (w_adv[s]) w_v_nxt[s] = w_vin[s];
    end
    if (flush) w_v_nxt = '0;
  end

  // Data stages: load only on a valid incoming beat so bubbles keep old data.
  for (genvar s = 0; s < DEPTH; s++) begin : g_stage
    if (s == 0) begin : g_head
      assign w_src[s] = data_i;
      assign w_vin[s] = valid_i;
    end else begin : g_body
      assign w_src[s] = r_data[s-1];
      assign w_vin[s] = r_v[s-1];
    end

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        r_data[s] <= '0;
      end else if (!flush && w_adv[s] && w_vin[s]) begin
        r_data[s] <= w_src[s];
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_v   <= '0;
      r_occ <= '0;
    end else begin
      r_v   <= w_v_nxt;
      r_occ <= popcnt(w_v_nxt);
    end
  end

  // BR tap stage: capture the slice of each lane on an output handshake.
  assign w_out_hs = r_v[DEPTH-1] & ready_i;

  always_comb begin
    w_br_slice = '0;
    for (int k = 0; k < LANES; k++) begin
      w_br_slice[k*BRD_WIDTH +: BRD_WIDTH] = r_data[DEPTH-1][k*P_WIDTH + BRD_LSB +: BRD_WIDTH];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_br     <= '0;
      r_br_vld <= 1'b0;
    end else if (flush) begin
      r_br_vld <= 1'b0;
    end else begin
      r_br_vld <= w_out_hs;
      if (w_out_hs) r_br <= w_br_slice;
    end
  end

  assign ready_o    = rst_n & w_adv[0];
  assign data_o     = r_data[DEPTH-1];
  assign valid_o    = r_v[DEPTH-1];
  assign br_o       = r_br;
  assign br_valid_o = r_br_vld;
  assign occ_o      = r_occ;

endmodule

// File: tb/tb_bu_outpipe_elastic.sv
// Scoreboard bench for bu_outpipe_elastic: a queue of accepted beats models the
// pipeline contents; a negedge monitor pops and checks data, BR taps and occupancy.
module tb_bu_outpipe_elastic;

  localparam int LANES = 16;
  localparam int PW    = 64;
  localparam int DEPTH = 2;
  localparam int BRW   = 20;
  localparam int DW    = LANES * PW;
  localparam int BWA   = LANES * BRW;

  logic          clk, rst_n, flush, valid_i, ready_i;
  logic [DW-1:0] data_i, data_o;
  logic          ready_o, valid_o, br_valid_o;
  logic [BWA-1:0] br_o;
  logic [3:0]    occ_o;

  // Second instance: narrow lanes and an offset BR slice.
  logic [127:0]  b_data_i, b_data_o;
  logic          b_valid_i, b_ready_o, b_valid_o, b_ready_i, b_br_valid_o, b_flush;
  logic [47:0]   b_br_o;
  logic [3:0]    b_occ_o;

  bu_outpipe_elastic #(.LANES(LANES), .P_WIDTH(PW), .DEPTH(DEPTH), .BRD_WIDTH(BRW), .BRD_LSB(0)) dut (
    .clk(clk), .rst_n(rst_n), .flush(flush), .data_i(data_i), .valid_i(valid_i),
    .ready_o(ready_o), .data_o(data_o), .valid_o(valid_o), .ready_i(ready_i),
    .br_o(br_o), .br_valid_o(br_valid_o), .occ_o(occ_o));

  bu_outpipe_elastic #(.LANES(4), .P_WIDTH(32), .DEPTH(1), .BRD_WIDTH(12), .BRD_LSB(8)) dut_b (
    .clk(clk), .rst_n(rst_n), .flush(b_flush), .data_i(b_data_i), .valid_i(b_valid_i),
    .ready_o(b_ready_o), .data_o(b_data_o), .valid_o(b_valid_o), .ready_i(b_ready_i),
    .br_o(b_br_o), .br_valid_o(b_br_valid_o), .occ_o(b_occ_o));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_mis = 0;
  int n_brv = 0;
  int n_hs_br = 0;
  logic [DW-1:0]  exp_q[$];
  logic           br_pend = 1'b0;
  logic [BWA-1:0] br_exp = '0;
  logic           rnd_ready = 1'b0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_mis++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  task automatic chk_data(input string nm, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_mis++;
      for (int k = 0; k < LANES; k++) begin
        if (act[k*PW +: PW] !== exp[k*PW +: PW]) begin
          $display("FAIL %s lane %0d: got %h want %h", nm, k, act[k*PW +: PW], exp[k*PW +: PW]);
          break;
        end
      end
    end
  endtask

  function automatic logic [BWA-1:0] br_of(input logic [DW-1:0] d);
    logic [BWA-1:0] r;
    for (int k = 0; k < LANES; k++) r[k*BRW +: BRW] = d[k*PW +: BRW];
    return r;
  endfunction

  function automatic logic [DW-1:0] rnd_beat();
    logic [DW-1:0] d;
    for (int i = 0; i < DW / 32; i++) d[i*32 +: 32] = $urandom;
    return d;
  endfunction

  function automatic logic [DW-1:0] dir_beat(input int j);
    logic [DW-1:0] d;
    for (int k = 0; k < LANES; k++)
      d[k*PW +: PW] = 64'h1000_0000_000A_BC00 + 64'(k) + (64'(j) << 32);
    return d;
  endfunction

  // Issue one beat; on acceptance the expected beat enters the scoreboard.
  task automatic send(input logic [DW-1:0] d);
    int  n;
    bit  acc;
    n = 0;
    acc = 1'b0;
    data_i  = d;
    valid_i = 1'b1;
    while (!acc && n < 300) begin
      @(negedge clk);
      acc = ready_o && !flush && rst_n;
      @(posedge clk);
      #1;
      if (acc) exp_q.push_back(d);
      n++;
    end
    if (!acc) begin
      n_cmp++;
      n_mis++;
      $display("FAIL send_timeout: got not-accepted want accepted");
    end
    valid_i = 1'b0;
  endtask

  task automatic idle(input int n);
    valid_i = 1'b0;
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 400) begin
      @(posedge clk);
      #1;
      n++;
    end
    idle(3);
    chk("drain_empty", 64'(exp_q.size()), 64'd0);
  endtask

  always begin
    @(posedge clk);
    #1;
    if (rnd_ready) ready_i = 1'($urandom_range(0, 1));
  end

  // Monitor: compares everything the DUT presents against the scoreboard.
  always @(negedge clk) begin
    if (!rst_n) begin
      exp_q.delete();
      br_pend = 1'b0;
    end else begin
      chk("br_valid", 64'(br_valid_o), 64'(br_pend));
      if (br_pend) chk("br_o", br_o[63:0], br_exp[63:0]);
      if (br_pend) chk("br_o_hi", 64'(br_o[BWA-1:BWA-60]), 64'(br_exp[BWA-1:BWA-60]));
      if (br_valid_o) n_brv++;
      br_pend = 1'b0;
      chk("occ", 64'(occ_o), 64'(exp_q.size()));
      if (valid_o && ready_i) begin
        if (exp_q.size() == 0) begin
          n_cmp++;
          n_mis++;
          $display("FAIL unexpected_beat: got valid_o=1 want no beat");
        end else begin
          chk_data("data_o", data_o, exp_q.pop_front());
          if (!flush) begin
            br_pend = 1'b1;
            br_exp  = br_of(data_o);
            n_hs_br++;
          end
        end
      end
      if (flush) exp_q.delete();
    end
  end

  initial begin
    #900000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0; flush = 1'b0; valid_i = 1'b0; ready_i = 1'b1; data_i = '0;
    b_flush = 1'b0; b_valid_i = 1'b0; b_ready_i = 1'b1; b_data_i = '0;
    #1;
    chk("rst_ready_o", 64'(ready_o), 64'd0);
    chk("rst_valid_o", 64'(valid_o), 64'd0);
    chk("rst_occ", 64'(occ_o), 64'd0);
    chk("rst_br_valid", 64'(br_valid_o), 64'd0);
    #12;
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Back-to-back beats with downstream always ready.
    send(dir_beat(0));
    chk("lat_edge1", 64'(valid_o), 64'd0);
    send(dir_beat(1));
    chk("lat_edge2", 64'(valid_o), 64'd1);
    send(dir_beat(2));
    chk("br_pulse", 64'(br_valid_o), 64'd1);
    chk("br_lane0", 64'(br_o[19:0]), 64'h0ABC00);
    chk("br_lane15", 64'(br_o[319:300]), 64'h0ABC0F);
    send(dir_beat(3));
    drain();

    // Stall: two beats fill the pipe, the third is refused until ready_i rises.
    ready_i = 1'b0;
    send(dir_beat(4));
    send(dir_beat(5));
    data_i = dir_beat(6);
    valid_i = 1'b1;
    @(negedge clk);
    chk("stall_ready_o", 64'(ready_o), 64'd0);
    chk("stall_occ", 64'(occ_o), 64'd2);
    @(posedge clk);
    #1;
    ready_i = 1'b1;
    send(dir_beat(6));
    drain();

    // Flush with a full pipe and a beat on the input.
    ready_i = 1'b0;
    send(dir_beat(7));
    send(dir_beat(8));
    data_i = dir_beat(9);
    valid_i = 1'b1;
    flush = 1'b1;
    @(posedge clk);
    #1;
    flush = 1'b0;
    valid_i = 1'b0;
    chk("flush_valid_o", 64'(valid_o), 64'd0);
    chk("flush_occ", 64'(occ_o), 64'd0);
    chk("flush_br_valid", 64'(br_valid_o), 64'd0);
    ready_i = 1'b1;
    idle(5);

    // Asynchronous reset mid-stream, released between edges.
    ready_i = 1'b0;
    send(dir_beat(10));
    #2;
    rst_n = 1'b0;
    #1;
    chk_data("arst_data_o", data_o, '0);
    chk("arst_br_o", br_o[63:0], 64'd0);
    chk("arst_valid_o", 64'(valid_o), 64'd0);
    chk("arst_br_valid", 64'(br_valid_o), 64'd0);
    chk("arst_occ", 64'(occ_o), 64'd0);
    chk("arst_ready_o", 64'(ready_o), 64'd0);
    @(negedge clk);
    #2;
    rst_n = 1'b1;
    ready_i = 1'b1;
    @(posedge clk);
    #1;
    send(dir_beat(11));
    chk("rst_lat_edge1", 64'(valid_o), 64'd0);
    @(posedge clk);
    #1;
    chk("rst_lat_edge2", 64'(valid_o), 64'd1);
    drain();

    // Offset BR slice on the narrow instance.
    b_data_i = {32'hFFFF_FFFF, 32'h0000_0000, 32'hFFF0_0FFF, 32'h00AB_C123};
    b_valid_i = 1'b1;
    @(posedge clk);
    #1;
    b_valid_i = 1'b0;
    chk("b_valid_o", 64'(b_valid_o), 64'd1);
    chk("b_occ", 64'(b_occ_o), 64'd1);
    chk("b_data_o", b_data_o[63:0], 64'hFFF0_0FFF_00AB_C123);
    @(posedge clk);
    #1;
    chk("b_br_valid", 64'(b_br_valid_o), 64'd1);
    chk("b_br_o", 64'(b_br_o), 64'hFFF0_0000_FBC1);
    @(posedge clk);
    #1;
    chk("b_br_valid_drop", 64'(b_br_valid_o), 64'd0);

    // Random traffic on both handshakes.
    rnd_ready = 1'b1;
    for (int i = 0; i < 1000; i++) begin
      send(rnd_beat());
      if ($urandom_range(0, 1) == 1) idle(1);
    end
    rnd_ready = 1'b0;
    @(posedge clk);
    #1;
    ready_i = 1'b1;
    drain();
    chk("br_count", 64'(n_brv), 64'(n_hs_br));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
